// File: rtl/log_conv_16.sv
// rtl/log_conv_16.sv - two-stage Mitchell log2 converter with valid/ready handshake
module log_conv_16 #(
  parameter int FRAC_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  input  logic [15:0]       in_lod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_k,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_zero
);

  // Stage 1: encoded characteristic plus the raw operand
  logic        s1_valid;
  logic [3:0]  s1_k;
  logic        s1_zero;
  logic [15:0] s1_data;

  // Stage 2: final result registers, driven straight to the outputs
  logic              s2_valid;
  logic [3:0]        s2_k;
  logic [FRAC_W-1:0] s2_frac;
  logic              s2_zero;

  logic              s2_load;
  logic              in_fire;
  logic [3:0]        enc_k;
  logic [15:0]       norm;
  logic [14:0]       frac15;
  logic [FRAC_W-1:0] frac_trunc;

  // Handshake: S2 takes new content when empty or draining; S1 follows S2.
  // in_ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    s2_load  = !s2_valid || out_ready;
    in_ready = rst_n && (!s1_valid || s2_load);
    in_fire  = in_valid && in_ready;
  end

  // Priority encode the leading-one vector; the highest set bit wins so a
  // multi-hot vector still yields the true characteristic.
  always_comb begin
    enc_k = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (in_lod[i]) enc_k = 4'(i);
    end
  end

  // Normalise: shift the leading one up to bit 15, keep the bits below it,
  // then truncate to the configured fraction width.
  always_comb begin
    norm       = s1_data << (4'd15 - s1_k);
    frac15     = norm[14:0];
    frac_trunc = frac15[14 -: FRAC_W];
  end

  // Stage 1 register: loads whenever in_ready (empty or advancing).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_k     <= 4'd0;
      s1_zero  <= 1'b0;
      s1_data  <= 16'd0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_fire) begin
        s1_k    <= enc_k;
        s1_zero <= (in_lod == 16'd0);
        s1_data <= in_data;
      end
    end
  end

  // Stage 2 register: holds while stalled, zero operands force a clean result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_k     <= 4'd0;
      s2_frac  <= '0;
      s2_zero  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_zero <= s1_zero;
        s2_k    <= s1_zero ? 4'd0 : s1_k;
        s2_frac <= s1_zero ? '0 : frac_trunc;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_k     = s2_k;
  assign out_frac  = s2_frac;
  assign out_zero  = s2_zero;

endmodule
